fc_layer_serial: RTL and testbench
==================================

# fc_layer_serial

Time-multiplexed fully-connected layer that sits directly downstream of the flatten stage: it consumes the flattened 1-D activation vector one element per beat, stores it, and computes `OUT_LEN` neuron outputs with a single multiply-accumulate unit. Each output is a signed fixed-point dot product plus bias, optionally passed through ReLU. Results stream out one neuron per beat to the next layer (next FC layer or softmax).

## Interface
- `WIDTH`, 16: signed fixed-point word width for activations, weights, bias and results.
- `FRAC`, 8: fractional bits in all words.
- `IN_LEN`, 48: flattened input vector length (CHANNELS*H*W of the upstream flatten stage).
- `OUT_LEN`, 10: neuron count.
- `RELU`, 1: 1 = clamp negative results to 0; 0 = pass through.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input element valid.
- `in_ready`  out  1  block accepts an input element.
- `in_data`  in  WIDTH  signed activation, in flatten order (ch, row, col).
- `p_we`  in  1  parameter write strobe.
- `p_addr`  in  clog2(OUT_LEN*IN_LEN+OUT_LEN)  weight addr j*IN_LEN+i; bias j at OUT_LEN*IN_LEN+j.
- `p_data`  in  WIDTH  signed weight/bias value.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_data`  out  WIDTH  signed neuron result.
- `out_last`  out  1  high with the result of neuron OUT_LEN-1.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, LOAD, MAC, EMIT.
- IDLE: `in_ready`=1. An input handshake stores element 0 and moves to LOAD (or straight to MAC if IN_LEN=1).
- LOAD: `in_ready`=1; each handshake writes element i to the activation buffer, i increments; handshake on element IN_LEN-1 moves to MAC with j=0.
- MAC: `in_ready`=0. One product per cycle, acc += x[i]*w[j][i], i = 0..IN_LEN-1; then one finalize cycle: result = sat_WIDTH(relu((acc >>> FRAC) + bias[j])), registered into `out_data`, move to EMIT.
- EMIT: `out_valid`=1, `out_data`/`out_last` held stable until `out_ready`. On handshake: if j<OUT_LEN-1, j++, clear acc, back to MAC; else go to IDLE.
- Arithmetic: products 2*WIDTH bits; accumulator 2*WIDTH+clog2(IN_LEN) bits, no overflow possible. Shift is arithmetic (truncation toward −inf). Bias added at WIDTH precision after sign extension. Saturation clamps to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Parameter writes take effect only when `busy`=0; a `p_we` while busy is ignored. Address ≥ OUT_LEN*IN_LEN+OUT_LEN is ignored.
- Parameter memories are not cleared by reset.

## Timing
- Reset values: `in_ready`=0 during reset, 1 in the first cycle after release; `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0; state IDLE, counters and accumulator 0.
- Reset mid-frame (any state) aborts the frame immediately; partial inputs and results are discarded.
- Latency: `out_valid` for neuron 0 rises IN_LEN+1 cycles after the cycle of the last input handshake. Each subsequent neuron's `out_valid` rises IN_LEN+1 cycles after the previous output handshake.
- `out_valid` drops in the cycle after an output handshake. Back-pressure (out_ready=0) stalls indefinitely with no loss.
- After the `out_last` handshake, `in_ready`=1 in the next cycle. The next frame's inputs are never accepted while MAC or EMIT is active.
- Input throughput: one element per cycle when `in_valid` is held high.

## Structure
- Shared `cnn_pkg`: WIDTH/FRAC defaults, the saturate function, and the ReLU function, so they are shared with the conv, maxpool and flatten stages.
- One sub-module `fc_mac`: signed multiply, accumulate, clear, and finalize (shift, bias add, ReLU, saturate). The FSM, counters, activation buffer and parameter RAMs stay in `fc_layer_serial`.

## Test plan
- IN_LEN=4, OUT_LEN=2, FRAC=8, RELU=0. Inputs 256,512,768,1024 (1,2,3,4). W0 all 256, W1 = 256,0,0,−256, biases 0/128 → outputs 2560 (10.0) then −640 (−3+0.5). `out_last` is high only on the second output. First `out_valid` comes 5 cycles after the last input.
- Same frame with RELU=1 → outputs 2560, 0.
- Saturation: inputs all 32767, weights all 32767, bias 32767 → 32767. Negated weights → −32768.
- Back-pressure: hold `out_ready`=0 for 20 cycles. `out_data` stays stable, `in_ready` stays 0, no result is lost. Random `in_valid` gaps give identical results.
- Assert `rst` during MAC of neuron 0. All outputs go to reset values asynchronously. A fresh frame after release produces correct results.
- `p_we` with a changed weight while busy is ignored (current frame unaffected). The same write in IDLE changes the next frame's result accordingly.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN word defaults, FC state encoding, ReLU and saturation helpers.
package cnn_pkg;
    localparam int CNN_WIDTH = 16;
    localparam int CNN_FRAC  = 8;

    typedef enum logic [1:0] {IDLE, LOAD, MAC, EMIT} fc_state_e;

    function automatic logic signed [63:0] relu(input logic signed [63:0] v);
        return v < 64'sd0 ? 64'sd0 : v;
    endfunction

    // Clamp v into the signed range of a w-bit word.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return v > hi ? hi : (v < lo ? lo : v);
    endfunction
endpackage

// File: rtl/fc_mac.sv
// fc_mac: signed multiply-accumulate with finalize (shift, bias, ReLU, saturate).
// Ports: clk/rst (async high); clr_i zeroes the accumulator; en_i adds x_i*w_i;
//        bias_i is added in finalize; res_o is the combinational finalized result.
module fc_mac
    import cnn_pkg::*;
#(
    parameter int WIDTH  = CNN_WIDTH,
    parameter int FRAC   = CNN_FRAC,
    parameter int IN_LEN = 48,
    parameter int RELU   = 1
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [WIDTH-1:0] x_i,
    input  logic signed [WIDTH-1:0] w_i,
    input  logic signed [WIDTH-1:0] bias_i,
    output logic signed [WIDTH-1:0] res_o
);
    localparam int AW = 2 * WIDTH + $clog2(IN_LEN);

    logic signed [AW-1:0]      acc_q, acc_d;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [63:0]        sum, act;

    assign prod  = x_i * w_i;
    assign acc_d = clr_i ? '0 : (en_i ? acc_q + AW'(prod) : acc_q);
    // Arithmetic shift drops fraction bits toward -inf before the bias is added.
    assign sum   = 64'(acc_q >>> FRAC) + 64'(bias_i);
    assign act   = RELU != 0 ? relu(sum) : sum;
    assign res_o = WIDTH'(saturate(act, WIDTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end
endmodule

// File: rtl/fc_layer_serial.sv
// fc_layer_serial: time-multiplexed fully-connected layer with one MAC unit.
// Ports: in_valid/in_ready/in_data stream the flattened activations;
//        p_we/p_addr/p_data write weights (j*IN_LEN+i) and biases (OUT_LEN*IN_LEN+j) while idle;
//        out_valid/out_ready/out_data/out_last stream one neuron result per beat; busy = not IDLE.
module fc_layer_serial
    import cnn_pkg::*;
#(
    parameter int  WIDTH   = CNN_WIDTH,
    parameter int  FRAC    = CNN_FRAC,
    parameter int  IN_LEN  = 48,
    parameter int  OUT_LEN = 10,
    parameter int  RELU    = 1,
    localparam int PN      = OUT_LEN * IN_LEN + OUT_LEN,
    localparam int AW      = $clog2(PN)
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    p_we,
    input  logic [AW-1:0]           p_addr,
    input  logic signed [WIDTH-1:0] p_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_last,
    output logic                    busy
);
    localparam int IW = $clog2(IN_LEN + 1);
    localparam int XW = IN_LEN > 1 ? $clog2(IN_LEN) : 1;
    localparam int JW = OUT_LEN > 1 ? $clog2(OUT_LEN) : 1;

    fc_state_e               state_q, state_d;
    logic [IW-1:0]           i_q, i_d;
    logic [JW-1:0]           j_q, j_d;
    logic signed [WIDTH-1:0] data_q, data_d;
    logic                    last_q, last_d;
    logic                    clr, en, in_hs;
    logic signed [WIDTH-1:0] xbuf [IN_LEN];
    logic signed [WIDTH-1:0] pmem [PN];
    logic signed [WIDTH-1:0] res;
    logic [AW-1:0]           waddr, baddr;

    assign in_ready  = !rst && (state_q == IDLE || state_q == LOAD);
    assign in_hs     = in_valid && in_ready;
    assign out_valid = state_q == EMIT;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign busy      = state_q != IDLE;
    assign waddr     = AW'(int'(j_q) * IN_LEN + int'(i_q));
    assign baddr     = AW'(OUT_LEN * IN_LEN + int'(j_q));

    // Buffers and parameter RAMs carry no reset so they map onto plain memory.
    always_ff @(posedge clk) begin
        if (in_hs) xbuf[i_q[XW-1:0]] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (p_we && !busy && int'(p_addr) < PN) pmem[p_addr] <= p_data;
    end

    fc_mac #(.WIDTH(WIDTH), .FRAC(FRAC), .IN_LEN(IN_LEN), .RELU(RELU)) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .en_i   (en),
        .x_i    (xbuf[i_q[XW-1:0]]),
        .w_i    (pmem[waddr]),
        .bias_i (pmem[baddr]),
        .res_o  (res)
    );

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        data_d  = data_q;
        last_d  = last_q;
        clr     = 1'b0;
        en      = 1'b0;
        case (state_q)
            IDLE, LOAD: if (in_hs) begin
                clr     = 1'b1;
                j_d     = '0;
                state_d = i_q == IW'(IN_LEN - 1) ? MAC : LOAD;
                i_d     = i_q == IW'(IN_LEN - 1) ? '0 : i_q + 1'b1;
            end
            // i_q == IN_LEN is the finalize cycle after the last product.
            MAC: if (i_q == IW'(IN_LEN)) begin
                state_d = EMIT;
                data_d  = res;
                last_d  = j_q == JW'(OUT_LEN - 1);
            end else begin
                en  = 1'b1;
                i_d = i_q + 1'b1;
            end
            EMIT: if (out_ready) begin
                clr     = 1'b1;
                i_d     = '0;
                j_d     = last_q ? '0 : j_q + 1'b1;
                state_d = last_q ? IDLE : MAC;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_fc_layer_serial.sv
// tb_fc_layer_serial: directed checks of fc_layer_serial with RELU=0 and RELU=1 instances in lockstep.
module tb_fc_layer_serial;
    localparam int IN_LEN  = 4;
    localparam int OUT_LEN = 2;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, p_we = 1'b0, out_ready = 1'b0;
    logic signed [15:0] in_data = '0, p_data = '0;
    logic [3:0] p_addr = '0;
    logic in_ready, out_valid, out_last, busy;
    logic signed [15:0] out_data;
    logic in_ready_r, out_valid_r, out_last_r, busy_r;
    logic signed [15:0] out_data_r;
    logic signed [15:0] xv [4];
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    fc_layer_serial #(.WIDTH(16), .FRAC(8), .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .RELU(0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .p_we(p_we), .p_addr(p_addr), .p_data(p_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    fc_layer_serial #(.WIDTH(16), .FRAC(8), .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .RELU(1)) u_relu (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
        .p_we(p_we), .p_addr(p_addr), .p_data(p_data), .out_valid(out_valid_r), .out_ready(out_ready),
        .out_data(out_data_r), .out_last(out_last_r), .busy(busy_r)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic wr(input int a, input int d);
        p_we   = 1'b1;
        p_addr = 4'(a);
        p_data = 16'(d);
        @(negedge clk);
        p_we   = 1'b0;
    endtask

    task automatic load(input int w0, input int w1f, input int w1m, input int w1l, input int b0, input int b1);
        for (int k = 0; k < 4; k++) wr(k, w0);
        wr(4, w1f);
        wr(5, w1m);
        wr(6, w1m);
        wr(7, w1l);
        wr(8, b0);
        wr(9, b1);
    endtask

    task automatic send(input logic signed [15:0] v, input int gap);
        int n = 0;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) chk("in_ready_wait", {31'b0, in_ready}, 1);
        @(negedge clk);
    endtask

    task automatic recv(input string tag, input int e, input int er, input bit last, input int stall);
        int lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            p_we = 1'b0;
            lat++;
        end
        chk({tag, "_lat"}, lat, IN_LEN + 1);
        chk({tag, "_data"}, out_data, e);
        chk({tag, "_data_relu"}, out_data_r, er);
        chk({tag, "_last"}, {31'b0, out_last}, {31'b0, last});
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 0);
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk({tag, "_hold_data"}, out_data, e);
            chk({tag, "_hold_valid"}, {31'b0, out_valid}, 1);
            chk({tag, "_hold_in_ready"}, {31'b0, in_ready}, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'b0, out_valid}, 0);
    endtask

    task automatic run_frame(input int gap_max, input int stall, input bit bw,
                             input int e0, input int e1, input int r0, input int r1);
        for (int k = 0; k < 4; k++) send(xv[k], $urandom_range(0, gap_max));
        in_valid = 1'b0;
        chk("busy_after_load", {31'b0, busy}, 1);
        if (bw) begin
            p_we   = 1'b1;
            p_addr = 4'd0;
            p_data = 16'sd0;
        end
        recv("n0", e0, r0, 1'b0, stall);
        recv("n1", e1, r1, 1'b1, stall);
        chk("in_ready_after_last", {31'b0, in_ready}, 1);
        chk("idle_after_last", {31'b0, busy}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 0);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", {31'b0, out_last}, 0);
        rst = 1'b0;
        #1 chk("release_in_ready", {31'b0, in_ready}, 1);
        @(negedge clk);

        load(256, 256, 0, -256, 0, 128);
        xv = '{16'sd256, 16'sd512, 16'sd768, 16'sd1024};
        run_frame(0, 0, 1'b0, 2560, -640, 2560, 0);
        run_frame(3, 20, 1'b0, 2560, -640, 2560, 0);

        for (int k = 0; k < 4; k++) send(xv[k], 0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_in_ready", {31'b0, in_ready}, 0);
        chk("abort_out_valid", {31'b0, out_valid}, 0);
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_out_data", out_data, 0);
        chk("abort_out_last", {31'b0, out_last}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frame(0, 0, 1'b0, 2560, -640, 2560, 0);

        run_frame(0, 0, 1'b1, 2560, -640, 2560, 0);
        wr(0, 0);
        run_frame(0, 0, 1'b0, 2304, -640, 2304, 0);
        wr(0, 256);

        load(32767, -32767, -32767, -32767, 32767, 32767);
        xv = '{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767};
        run_frame(0, 0, 1'b0, 32767, -32768, 32767, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
